// File: rtl/rtc_access_sched_if.sv
// rtc_access_sched_if: groups the two requester handshakes and the multiplexed
// RTC bus pins. slave = scheduler view, master = requester/RTC-side view.
interface rtc_access_sched_if;
    logic       req0, rw0, done0;
    logic [7:0] addr0, wdata0;
    logic       req1, rw1, done1;
    logic [7:0] addr1, wdata1;
    logic [7:0] rdata;
    logic       busy;
    logic       AD, CS, RD, WR;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in;

    modport slave (
        input  req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, bus_in,
        output done0, done1, rdata, busy, AD, CS, RD, WR, bus_out, bus_oe
    );

    modport master (
        output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, bus_in,
        input  done0, done1, rdata, busy, AD, CS, RD, WR, bus_out, bus_oe
    );
endinterface

// File: rtl/rtc_access_sched.sv
// rtc_access_sched: two-requester arbiter + sequencer for a multiplexed
// (address phase, data phase) active-low RTC bus. All pin outputs are
// registered, derived from the next state, so they line up with state_q.
// Optional feature macro: RTC_SCHED_RR_EN (round-robin arbitration);
// undefined -> fixed priority, requester 0 always wins.
// Timing parameters of 0 are clamped to 1; values above 256 are truncated.
module rtc_access_sched #(
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 4,
    parameter int T_HOLD   = 2,
    parameter int T_RECOV  = 4
) (
    input logic              clk,
    input logic              rst,
    rtc_access_sched_if.slave sif
);
    localparam int TS = (T_SETUP  < 1) ? 1 : T_SETUP;
    localparam int TB = (T_STROBE < 1) ? 1 : T_STROBE;
    localparam int TH = (T_HOLD   < 1) ? 1 : T_HOLD;
    localparam int TR = (T_RECOV  < 1) ? 1 : T_RECOV;

    typedef enum logic [3:0] {
        S_IDLE, S_A_SETUP, S_A_STROBE, S_A_HOLD, S_A_RECOV,
        S_D_SETUP, S_D_STROBE, S_D_HOLD, S_D_RECOV, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       gnt_q, gnt_d, rw_q, rw_d, win;
    logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic       cs_q, cs_d, ad_q, ad_d, rd_q, rd_d, wr_q, wr_d;
    logic       oe_q, oe_d, busy_q, busy_d;
    logic       done0_q, done0_d, done1_q, done1_d;
    logic [7:0] bout_q, bout_d;
`ifdef RTC_SCHED_RR_EN
    logic       ptr_q, ptr_d;   // requester preferred on a tie
`endif

    // Dwell length (minus one) loaded into the counter on state entry.
    function automatic logic [7:0] load_of(state_t s);
        case (s)
            S_A_SETUP, S_D_SETUP:   load_of = 8'(TS - 1);
            S_A_STROBE, S_D_STROBE: load_of = 8'(TB - 1);
            S_A_HOLD, S_D_HOLD:     load_of = 8'(TH - 1);
            S_A_RECOV, S_D_RECOV:   load_of = 8'(TR - 1);
            default:                load_of = 8'd0;
        endcase
    endfunction

    function automatic state_t next_of(state_t s);
        case (s)
            S_A_SETUP:  next_of = S_A_STROBE;
            S_A_STROBE: next_of = S_A_HOLD;
            S_A_HOLD:   next_of = S_A_RECOV;
            S_A_RECOV:  next_of = S_D_SETUP;
            S_D_SETUP:  next_of = S_D_STROBE;
            S_D_STROBE: next_of = S_D_HOLD;
            S_D_HOLD:   next_of = S_D_RECOV;
            S_D_RECOV:  next_of = S_DONE;
            default:    next_of = S_IDLE;
        endcase
    endfunction

    // Next state: arbitration in IDLE, latch the winner, then timed phase walk.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef RTC_SCHED_RR_EN
        ptr_d   = ptr_q;
        win     = (sif.req0 && sif.req1) ? ptr_q : sif.req1;
`else
        win     = !sif.req0;
`endif
        case (state_q)
            S_IDLE: begin
                if (sif.req0 || sif.req1) begin
                    gnt_d   = win;
                    rw_d    = win ? sif.rw1    : sif.rw0;
                    addr_d  = win ? sif.addr1  : sif.addr0;
                    wdata_d = win ? sif.wdata1 : sif.wdata0;
`ifdef RTC_SCHED_RR_EN
                    ptr_d   = !win;
`endif
                    state_d = S_A_SETUP;
                    cnt_d   = load_of(S_A_SETUP);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (cnt_q == 8'd0) begin
                    state_d = next_of(state_q);
                    cnt_d   = load_of(next_of(state_q));
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase
        // Read data is taken on the final RD-low cycle.
        if (state_q == S_D_STROBE && cnt_q == 8'd0 && rw_q)
            rdata_d = sif.bus_in;
    end

    // Pin values for the state being entered, so registered pins track state_q.
    always_comb begin
        cs_d    = 1'b1;
        ad_d    = 1'b1;
        rd_d    = 1'b1;
        wr_d    = 1'b1;
        oe_d    = 1'b0;
        bout_d  = 8'h00;
        done0_d = 1'b0;
        done1_d = 1'b0;
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_A_SETUP, S_A_HOLD: begin
                cs_d = 1'b0; ad_d = 1'b0; oe_d = 1'b1; bout_d = addr_d;
            end
            S_A_STROBE: begin
                cs_d = 1'b0; ad_d = 1'b0; oe_d = 1'b1; bout_d = addr_d; wr_d = 1'b0;
            end
            S_D_SETUP, S_D_HOLD: begin
                cs_d = 1'b0; oe_d = !rw_d; bout_d = rw_d ? 8'h00 : wdata_d;
            end
            S_D_STROBE: begin
                cs_d = 1'b0; oe_d = !rw_d; bout_d = rw_d ? 8'h00 : wdata_d;
                rd_d = !rw_d;
                wr_d = rw_d;
            end
            S_DONE: begin
                done0_d = !gnt_d;
                done1_d = gnt_d;
            end
            default: ;
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;  cnt_q <= 8'd0;
            gnt_q   <= 1'b0;    rw_q  <= 1'b0;
            addr_q  <= 8'h00;   wdata_q <= 8'h00;  rdata_q <= 8'h00;
            cs_q <= 1'b1; ad_q <= 1'b1; rd_q <= 1'b1; wr_q <= 1'b1;
            oe_q <= 1'b0; bout_q <= 8'h00; busy_q <= 1'b0;
            done0_q <= 1'b0; done1_q <= 1'b0;
`ifdef RTC_SCHED_RR_EN
            ptr_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;
            gnt_q   <= gnt_d;    rw_q  <= rw_d;
            addr_q  <= addr_d;   wdata_q <= wdata_d;  rdata_q <= rdata_d;
            cs_q <= cs_d; ad_q <= ad_d; rd_q <= rd_d; wr_q <= wr_d;
            oe_q <= oe_d; bout_q <= bout_d; busy_q <= busy_d;
            done0_q <= done0_d; done1_q <= done1_d;
`ifdef RTC_SCHED_RR_EN
            ptr_q <= ptr_d;
`endif
        end
    end

    assign sif.CS      = cs_q;
    assign sif.AD      = ad_q;
    assign sif.RD      = rd_q;
    assign sif.WR      = wr_q;
    assign sif.bus_oe  = oe_q;
    assign sif.bus_out = bout_q;
    assign sif.busy    = busy_q;
    assign sif.done0   = done0_q;
    assign sif.done1   = done1_q;
    assign sif.rdata   = rdata_q;
endmodule
